video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16; parameter H_SYNC, default 96; parameter H_BP, default 48. The horizontal total is 800.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480; V_FP, default 10; V_SYNC, default 2; V_BP, default 33. The vertical total is 525.
REQ-004 The block SHALL have parameter SYNC_POL, default 0, giving the asserted level of hsync/vsync (0 = active-low).
REQ-005 The block SHALL have parameter PIPE_DELAY, default 2, giving the cycles by which hsync/vsync/vde lag the fetch coordinates (range 1..8).
REQ-006 Ports:
gpu_clk  in  1  pixel clock; sole clock
rst  in  1  synchronous, active-high reset
fetch_x  out  10  current horizontal counter
fetch_y  out  10  current vertical counter
fetch_active  out  1  counters inside the visible region
tile_index  out  12  background tile number address, row*80+col
tile_px  out  3  pixel column within tile (x[2:0])
tile_py  out  4  pixel row within tile (y[3:0])
line_start  out  1  one-cycle pulse at h=0
frame_start  out  1  one-cycle pulse at h=0, v=0
hsync  out  1  delayed horizontal sync
vsync  out  1  delayed vertical sync
vde  out  1  delayed video data enable

Function
REQ-007 h_cnt SHALL count 0..799 and increment every gpu_clk cycle; 799 SHALL wrap to 0.
REQ-008 v_cnt SHALL increment only on the cycle h_cnt wraps; 524 wrapping with h_cnt SHALL return v_cnt to 0.
REQ-009 fetch_x/fetch_y SHALL equal h_cnt/v_cnt in the same cycle, as registered outputs.
REQ-010 fetch_active SHALL be 1 iff h_cnt<640 and v_cnt<480.
REQ-011 Raw hsync SHALL be asserted iff 656<=h_cnt<752; raw vsync SHALL be asserted iff 490<=v_cnt<492, for the whole line, independent of h_cnt.
REQ-012 tile_index SHALL be (v_cnt>>4)*80 + (h_cnt>>3), computed without a multiplier (shift-add), 12 bits, range 0..2399.
REQ-013 tile_px and tile_py SHALL be h_cnt[2:0] and v_cnt[3:0].
REQ-014 tile_index, tile_px and tile_py SHALL be 0 when fetch_active=0.
REQ-015 line_start SHALL be 1 exactly when h_cnt=0. frame_start SHALL be 1 exactly when h_cnt=0 and v_cnt=0.
REQ-016 hsync, vsync and vde SHALL be the raw sync/fetch_active values delayed by exactly PIPE_DELAY registers, so that vde rises PIPE_DELAY cycles after fetch_active.
REQ-017 hsync/vsync SHALL be driven at level SYNC_POL when asserted and at the inverted level otherwise.
REQ-018 All outputs SHALL be registered, with no combinational path from rst to any output.
REQ-019 Counter arithmetic SHALL be derived from the parameters. Totals SHALL fit in 10 bits; a parameter set exceeding 1023 is unsupported.

Reset
REQ-020 While rst=1 at a gpu_clk edge, the block SHALL set h_cnt=v_cnt=0, and every stage of the delay line SHALL be set to deasserted sync (level !SYNC_POL) with vde=0.
REQ-021 During reset, the block SHALL drive fetch_x=fetch_y=0, fetch_active=0, tile_index=tile_px=tile_py=0 and line_start=frame_start=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately; no partial sync pulse SHALL be emitted after rst deasserts other than through flushed inactive values.
REQ-023 In the first cycle after rst deasserts, the block SHALL show h_cnt=0, v_cnt=0, fetch_active=1, frame_start=1 and line_start=1.

Verification
REQ-024 Release reset, then check cycle 0: frame_start=1, fetch_active=1, tile_index=0 -> vde rises at cycle 2 and hsync=vsync=1.
REQ-025 First line: fetch_active falls at cycle 640 -> vde falls at 642; hsync low over cycles 658..753 (96 cycles); line_start again at cycle 800.
REQ-026 Tile addressing: at h=639, v=479 -> tile_index=2399, tile_px=7, tile_py=15. At h=8, v=16 -> tile_index=81. At h=640 -> tile_index=0.
REQ-027 Frame timing: vsync low from cycle 392000+2 for 1600 cycles; next frame_start at cycle 420000; v_cnt wraps 524->0 together with h_cnt wrap.
REQ-028 Reset mid-frame at v=300, h=400 for 3 cycles -> outputs at reset values during rst; the delay line is flushed; after release the counters restart at 0,0 with frame_start=1.
REQ-029 Parameter sweep with PIPE_DELAY=5 and SYNC_POL=1 -> vde lags fetch_active by exactly 5 cycles; hsync is high only over 96-cycle windows.

Source files
------------

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for a tile-based video pipeline. A horizontal
// counter h_cnt and a vertical counter v_cnt scan the frame. The block emits
// the current fetch coordinates, the background tile address for the fetch
// stage, and line/frame start pulses. hsync, vsync and vde come out of a
// PIPE_DELAY-deep delay line so that they line up with pixels leaving a
// fetch pipeline of that depth.
//
// Parameters
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing in pixels (total <= 1023)
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing in lines   (total <= 1023)
//   SYNC_POL                   level of hsync/vsync when asserted (0 = low)
//   PIPE_DELAY                 sync/vde lag behind fetch coordinates (1..8)
//
// Ports
//   gpu_clk       pixel clock, the only clock
//   rst           synchronous active-high reset
//   fetch_x/y     current h_cnt / v_cnt
//   fetch_active  counters are inside the visible region
//   tile_index    (v_cnt>>4)*80 + (h_cnt>>3), 0 outside the visible region
//   tile_px/py    pixel column/row within the tile, 0 outside visible region
//   line_start    one-cycle pulse at h_cnt == 0
//   frame_start   one-cycle pulse at h_cnt == 0 and v_cnt == 0
//   hsync/vsync   delayed sync outputs at SYNC_POL polarity
//   vde           delayed video data enable
//
// Every output is a flop. The decoded outputs are computed from the
// next-state counter values so that they agree with fetch_x/fetch_y in the
// same cycle.
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 2
) (
    input  logic        gpu_clk,
    input  logic        rst,
    output logic [9:0]  fetch_x,
    output logic [9:0]  fetch_y,
    output logic        fetch_active,
    output logic [11:0] tile_index,
    output logic [2:0]  tile_px,
    output logic [3:0]  tile_py,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        vde
);

    // Timing landmarks. All counter arithmetic is derived from the
    // parameters; totals above 1023 do not fit the 10-bit counters.
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    // Counter state. fetch_x/fetch_y are the counter flops themselves.
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    // Cleared by reset. The first edge after reset loads the 0,0 decode
    // instead of advancing, so the first cycle out of reset shows the
    // start of a frame with fetch_active and frame_start already valid.
    logic       running;

    // Raw (undelayed, logical) sync flags aligned with h_cnt/v_cnt.
    logic       hs_raw_q;
    logic       vs_raw_q;

    // Next-state values and their decode.
    logic [9:0]  h_nxt;
    logic [9:0]  v_nxt;
    logic        act_nxt;
    logic        hs_raw_nxt;
    logic        vs_raw_nxt;
    logic [5:0]  tile_row;
    logic [6:0]  tile_col;
    logic [11:0] tile_nxt;

    // Delay line, stored at physical sync level.
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    logic [PIPE_DELAY-1:0] de_pipe;

    assign fetch_x = h_cnt;
    assign fetch_y = v_cnt;

    // -----------------------------------------------------------------------
    // Next counter values
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path through the block leaves it unassigned (which would infer a
        // latch).
        h_nxt = '0;
        v_nxt = '0;
        if (running) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
                v_nxt = v_cnt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decode of the next counter values
    // -----------------------------------------------------------------------
    always_comb begin
        act_nxt    = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
        hs_raw_nxt = (h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END);
        // Vertical sync covers whole lines, independent of h.
        vs_raw_nxt = (v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END);

        // row*80 + col as row*64 + row*16 + col; no multiplier.
        tile_row = v_nxt[9:4];
        tile_col = h_nxt[9:3];
        tile_nxt = {tile_row, 6'b0}
                 + {2'b0, tile_row, 4'b0}
                 + {5'b0, tile_col};
    end

    // -----------------------------------------------------------------------
    // Counters and registered fetch-side outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge gpu_clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the values from before this edge, regardless of statement
        // order.
        if (rst) begin
            running      <= 1'b0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            fetch_active <= 1'b0;
            tile_index   <= '0;
            tile_px      <= '0;
            tile_py      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            hs_raw_q     <= 1'b0;
            vs_raw_q     <= 1'b0;
        end else begin
            running      <= 1'b1;
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            fetch_active <= act_nxt;
            tile_index   <= act_nxt ? tile_nxt   : 12'd0;
            tile_px      <= act_nxt ? h_nxt[2:0] : 3'd0;
            tile_py      <= act_nxt ? v_nxt[3:0] : 4'd0;
            line_start   <= (h_nxt == 10'd0);
            frame_start  <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
            hs_raw_q     <= hs_raw_nxt;
            vs_raw_q     <= vs_raw_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Sync / data-enable delay line
    // -----------------------------------------------------------------------
    always_ff @(posedge gpu_clk) begin
        // NOTE: this shift register is reset on purpose. A reset mid-frame
        // must not let a half-finished sync pulse or vde stream drain out
        // afterwards, so every stage is forced to the inactive level.
        if (rst) begin
            hs_pipe <= {PIPE_DELAY{SYNC_OFF}};
            vs_pipe <= {PIPE_DELAY{SYNC_OFF}};
            de_pipe <= '0;
        end else begin
            hs_pipe[0] <= hs_raw_q ? SYNC_ON : SYNC_OFF;
            vs_pipe[0] <= vs_raw_q ? SYNC_ON : SYNC_OFF;
            de_pipe[0] <= fetch_active;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
            end
        end
    end

    // The last stage is a flop, so these remain registered outputs.
    assign hsync = hs_pipe[PIPE_DELAY-1];
    assign vsync = vs_pipe[PIPE_DELAY-1];
    assign vde   = de_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Three instances share one clock and reset:
//   d : default 640x480 timing, PIPE_DELAY=2, active-low sync
//   s : small 24x17 raster for whole-frame and vertical-wrap timing
//   p : default horizontal timing, short 7-line frame, PIPE_DELAY=5,
//       active-high sync
// A model computes every output from n, the number of cycles since reset
// release, using plain division/modulo on the timing parameters. Directed
// literal checks pin selected cycles.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    logic gpu_clk = 1'b0;
    logic rst     = 1'b1;

    always #5 gpu_clk = ~gpu_clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic [11:0] ti;
        logic [2:0]  px;
        logic [3:0]  py;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
    } out_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Cycle index since reset release; -1 while in reset.
    int n          = -1;
    bit seen_reset = 1'b0;

    always @(posedge gpu_clk) begin
        if (rst) begin
            n          <= -1;
            seen_reset <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    // ---------------- DUT instances ----------------
    logic [9:0]  d_x, d_y, s_x, s_y, p_x, p_y;
    logic        d_act, s_act, p_act;
    logic [11:0] d_ti, s_ti, p_ti;
    logic [2:0]  d_px, s_px, p_px;
    logic [3:0]  d_py, s_py, p_py;
    logic        d_ls, d_fs, d_hs, d_vs, d_de;
    logic        s_ls, s_fs, s_hs, s_vs, s_de;
    logic        p_ls, p_fs, p_hs, p_vs, p_de;

    video_timing_gen u_d (
        .gpu_clk(gpu_clk), .rst(rst),
        .fetch_x(d_x), .fetch_y(d_y), .fetch_active(d_act),
        .tile_index(d_ti), .tile_px(d_px), .tile_py(d_py),
        .line_start(d_ls), .frame_start(d_fs),
        .hsync(d_hs), .vsync(d_vs), .vde(d_de)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_s (
        .gpu_clk(gpu_clk), .rst(rst),
        .fetch_x(s_x), .fetch_y(s_y), .fetch_active(s_act),
        .tile_index(s_ti), .tile_px(s_px), .tile_py(s_py),
        .line_start(s_ls), .frame_start(s_fs),
        .hsync(s_hs), .vsync(s_vs), .vde(s_de)
    );

    video_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .PIPE_DELAY(5)
    ) u_p (
        .gpu_clk(gpu_clk), .rst(rst),
        .fetch_x(p_x), .fetch_y(p_y), .fetch_active(p_act),
        .tile_index(p_ti), .tile_px(p_px), .tile_py(p_py),
        .line_start(p_ls), .frame_start(p_fs),
        .hsync(p_hs), .vsync(p_vs), .vde(p_de)
    );

    out_t d_o, s_o, p_o;
    assign d_o = {d_x, d_y, d_act, d_ti, d_px, d_py, d_ls, d_fs, d_hs, d_vs, d_de};
    assign s_o = {s_x, s_y, s_act, s_ti, s_px, s_py, s_ls, s_fs, s_hs, s_vs, s_de};
    assign p_o = {p_x, p_y, p_act, p_ti, p_px, p_py, p_ls, p_fs, p_hs, p_vs, p_de};

    // ---------------- model ----------------
    // Expected outputs at cycle n (n < 0 means held in reset).
    function automatic out_t model(input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf,
                                   input int vs, input int vb, input int pd,
                                   input logic pol, input int cyc);
        out_t o;
        int   ht;
        int   vt;
        int   h;
        int   v;
        int   m;
        int   hd;
        int   vd;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        o    = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        if (cyc < 0) return o;
        h     = cyc % ht;
        v     = (cyc / ht) % vt;
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.act = (h < ha) && (v < va);
        if (o.act) begin
            o.ti = 12'((v / 16) * 80 + h / 8);
            o.px = 3'(h % 8);
            o.py = 4'(v % 16);
        end
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        // Delayed outputs reflect the raster pd cycles ago, or the
        // inactive levels if that lies before reset release.
        m = cyc - pd;
        if (m >= 0) begin
            hd   = m % ht;
            vd   = (m / ht) % vt;
            o.hs = ((hd >= ha + hf) && (hd < ha + hf + hs)) ? pol : ~pol;
            o.vs = ((vd >= va + vf) && (vd < va + vf + vs)) ? pol : ~pol;
            o.de = (hd < ha) && (vd < va);
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at n=%0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    // Per-cycle comparison of all three instances against the model.
    always @(negedge gpu_clk) begin
        if (seen_reset) begin
            check("d_model", 64'(d_o), 64'(model(640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, n)));
            check("s_model", 64'(s_o), 64'(model(16, 2, 4, 2, 12, 1, 2, 2, 2, 1'b0, n)));
            check("p_model", 64'(p_o), 64'(model(640, 16, 96, 48, 4, 1, 1, 1, 5, 1'b1, n)));
        end
    end

    // Wait (on the sampling edge) until cycle index target is shown.
    task automatic wait_n(input int target);
        for (int i = 0; i < 30000; i++) begin
            @(negedge gpu_clk);
            if (n == target) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_n timeout: n=%0d, expected to reach %0d", n, target);
    endtask

    // ---------------- directed stimulus and literal checks ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge gpu_clk);
        check("rst_x",   64'(d_x),   64'd0);
        check("rst_act", 64'(d_act), 64'd0);
        check("rst_ls",  64'(d_ls),  64'd0);
        check("rst_fs",  64'(d_fs),  64'd0);
        check("rst_hs",  64'(d_hs),  64'd1);
        check("rst_de",  64'(d_de),  64'd0);
        check("rst_p_hs", 64'(p_hs), 64'd0);
        rst = 1'b0;

        wait_n(0);
        check("c0_fs",  64'(d_fs),  64'd1);
        check("c0_ls",  64'(d_ls),  64'd1);
        check("c0_act", 64'(d_act), 64'd1);
        check("c0_ti",  64'(d_ti),  64'd0);
        check("c0_hs",  64'(d_hs),  64'd1);
        check("c0_vs",  64'(d_vs),  64'd1);
        check("c0_de",  64'(d_de),  64'd0);
        check("c0_p_hs", 64'(p_hs), 64'd0);
        wait_n(1);    check("c1_de",   64'(d_de), 64'd0);
        wait_n(2);    check("c2_de",   64'(d_de), 64'd1);
        wait_n(4);    check("p4_de",   64'(p_de), 64'd0);
        wait_n(5);    check("p5_de",   64'(p_de), 64'd1);

        // Small raster: vsync low 314..361, wrap to next frame at 408.
        wait_n(313);  check("s313_vs", 64'(s_vs), 64'd1);
        wait_n(314);  check("s314_vs", 64'(s_vs), 64'd0);
        wait_n(361);  check("s361_vs", 64'(s_vs), 64'd0);
        wait_n(362);  check("s362_vs", 64'(s_vs), 64'd1);
        wait_n(407);
        check("s407_x",  64'(s_x),  64'd23);
        check("s407_y",  64'(s_y),  64'd16);
        check("s407_fs", 64'(s_fs), 64'd0);
        wait_n(408);
        check("s408_fs", 64'(s_fs), 64'd1);
        check("s408_x",  64'(s_x),  64'd0);
        check("s408_y",  64'(s_y),  64'd0);

        // First default line.
        wait_n(639);  check("d639_act", 64'(d_act), 64'd1);
                      check("d639_ti",  64'(d_ti),  64'd79);
        wait_n(640);  check("d640_act", 64'(d_act), 64'd0);
                      check("d640_ti",  64'(d_ti),  64'd0);
        wait_n(641);  check("d641_de",  64'(d_de),  64'd1);
        wait_n(642);  check("d642_de",  64'(d_de),  64'd0);
        wait_n(644);  check("p644_de",  64'(p_de),  64'd1);
        wait_n(645);  check("p645_de",  64'(p_de),  64'd0);
        wait_n(657);  check("d657_hs",  64'(d_hs),  64'd1);
        wait_n(658);  check("d658_hs",  64'(d_hs),  64'd0);
        wait_n(660);  check("p660_hs",  64'(p_hs),  64'd0);
        wait_n(661);  check("p661_hs",  64'(p_hs),  64'd1);
        wait_n(753);  check("d753_hs",  64'(d_hs),  64'd0);
        wait_n(754);  check("d754_hs",  64'(d_hs),  64'd1);
        wait_n(756);  check("p756_hs",  64'(p_hs),  64'd1);
        wait_n(757);  check("p757_hs",  64'(p_hs),  64'd0);
        wait_n(799);  check("d799_x",   64'(d_x),   64'd799);
                      check("d799_ls",  64'(d_ls),  64'd0);
        wait_n(800);
        check("d800_ls", 64'(d_ls), 64'd1);
        check("d800_x",  64'(d_x),  64'd0);
        check("d800_y",  64'(d_y),  64'd1);
        check("d800_fs", 64'(d_fs), 64'd0);

        // Short frame with active-high sync: vsync high 4005..4804.
        wait_n(4004); check("p4004_vs", 64'(p_vs), 64'd0);
        wait_n(4005); check("p4005_vs", 64'(p_vs), 64'd1);
        wait_n(4804); check("p4804_vs", 64'(p_vs), 64'd1);
        wait_n(4805); check("p4805_vs", 64'(p_vs), 64'd0);
        wait_n(5600); check("p5600_fs", 64'(p_fs), 64'd1);

        // Tile addressing boundaries.
        wait_n(15 * 800 + 639);
        check("t639_15_ti", 64'(d_ti), 64'd79);
        check("t639_15_px", 64'(d_px), 64'd7);
        check("t639_15_py", 64'(d_py), 64'd15);
        wait_n(15 * 800 + 640);
        check("t640_15_ti", 64'(d_ti), 64'd0);
        check("t640_15_px", 64'(d_px), 64'd0);
        wait_n(16 * 800 + 7);
        check("t7_16_ti",   64'(d_ti), 64'd80);
        wait_n(16 * 800 + 8);
        check("t8_16_ti",   64'(d_ti), 64'd81);
        check("t8_16_px",   64'(d_px), 64'd0);
        check("t8_16_py",   64'(d_py), 64'd0);

        // Reset mid-line while hsync is asserted.
        wait_n(16 * 800 + 700);
        check("pre_rst_hs", 64'(d_hs), 64'd0);
        rst = 1'b1;
        @(negedge gpu_clk);
        check("mid_rst_hs",  64'(d_hs),  64'd1);
        check("mid_rst_x",   64'(d_x),   64'd0);
        check("mid_rst_y",   64'(d_y),   64'd0);
        check("mid_rst_ti",  64'(d_ti),  64'd0);
        check("mid_rst_de",  64'(d_de),  64'd0);
        check("mid_rst_php", 64'(p_hs),  64'd0);
        repeat (2) @(negedge gpu_clk);
        rst = 1'b0;
        wait_n(0);
        check("rel_fs", 64'(d_fs), 64'd1);
        check("rel_x",  64'(d_x),  64'd0);
        check("rel_y",  64'(d_y),  64'd0);
        check("rel_hs", 64'(d_hs), 64'd1);
        wait_n(1);    check("rel1_de", 64'(d_de), 64'd0);
        wait_n(2);    check("rel2_de", 64'(d_de), 64'd1);
        wait_n(1700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
